// File: rtl/audio_pkg.sv
// -----------------------------------------------------------------------------
// audio_pkg
// Shared definitions for the audio path (receive path, sample registers,
// processing stages and the I2S transmitter).
//   AUDIO_WIDTH     default bits per channel sample
//   AUDIO_CLK_DIV   default clk cycles per bclk half-period
//   stereo_sample_t left/right pair at the default sample width
// -----------------------------------------------------------------------------
package audio_pkg;

    localparam int unsigned AUDIO_WIDTH   = 16;
    localparam int unsigned AUDIO_CLK_DIV = 4;

    typedef struct packed {
        logic [AUDIO_WIDTH-1:0] left;
        logic [AUDIO_WIDTH-1:0] right;
    } stereo_sample_t;

endpackage

// File: rtl/i2s_clk_gen.sv
// -----------------------------------------------------------------------------
// i2s_clk_gen
// Divides the system clock down to the I2S bit clock.
// Ports:
//   clk     system clock, rising edge
//   reset   synchronous, active-high reset
//   bclk_o  registered bit clock, toggles once every CLK_DIV clk cycles
//   fall_o  one-cycle strobe: bclk_o goes low on the next clk edge
// -----------------------------------------------------------------------------
module i2s_clk_gen
    import audio_pkg::*;
#(
    parameter int unsigned CLK_DIV = AUDIO_CLK_DIV
) (
    input  logic clk,
    input  logic reset,
    output logic bclk_o,
    output logic fall_o
);

    // With CLK_DIV == 1 the counter is a single bit that never leaves 0.
    localparam int unsigned        DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             bclk_q, bclk_d;
    logic             tick;

    assign tick = (div_cnt_q == DIV_LAST);

    always_comb begin
        div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
        bclk_d    = bclk_q ^ tick;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt_q <= '0;
            bclk_q    <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            bclk_q    <= bclk_d;
        end
    end

    assign bclk_o = bclk_q;
    // A tick while bclk is high is the edge on which bclk falls.
    assign fall_o = tick & bclk_q;

endmodule

// File: rtl/i2s_transmitter.sv
// -----------------------------------------------------------------------------
// i2s_transmitter
// Serializes stereo sample pairs into an I2S stream for the codec DAC.
// One pair is accepted per frame into a single holding buffer; at each frame
// start the buffer is moved into a 2*WIDTH bit shift register and shifted out
// MSB first, left channel then right channel.
// Ports:
//   clk       system clock, rising edge
//   reset     synchronous, active-high reset
//   left      left sample (two's complement)
//   right     right sample (two's complement)
//   valid     left/right pair presented
//   ready     holding buffer empty; transfer on valid && ready
//   bclk      I2S bit clock (registered)
//   lrclk     I2S word select, 0 = left, 1 = right (registered)
//   sdata     I2S serial data, MSB first (registered)
//   underrun  one-cycle pulse when a frame starts with no sample buffered
// -----------------------------------------------------------------------------
module i2s_transmitter
    import audio_pkg::*;
#(
    parameter int unsigned WIDTH   = AUDIO_WIDTH,
    parameter int unsigned CLK_DIV = AUDIO_CLK_DIV
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] left,
    input  logic [WIDTH-1:0] right,
    input  logic             valid,
    output logic             ready,
    output logic             bclk,
    output logic             lrclk,
    output logic             sdata,
    output logic             underrun
);

    localparam int unsigned       FRAME_BITS   = 2 * WIDTH;
    localparam int unsigned       IDX_W        = $clog2(FRAME_BITS);
    localparam logic [IDX_W-1:0]  IDX_LAST     = IDX_W'(FRAME_BITS - 1);
    localparam logic [IDX_W-1:0]  IDX_LEFT_END = IDX_W'(WIDTH - 1);

    logic                  fall;
    logic                  accept;
    logic                  frame_start;

    logic                  buf_full_q, buf_full_d;
    logic [WIDTH-1:0]      left_buf_q;
    logic [WIDTH-1:0]      right_buf_q;
    logic [IDX_W-1:0]      bit_idx_q, bit_idx_d;
    logic [FRAME_BITS-1:0] shreg_q, shreg_d;
    logic                  lrclk_q, lrclk_d;
    logic                  underrun_q, underrun_d;

    i2s_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .clk    (clk),
        .reset  (reset),
        .bclk_o (bclk),
        .fall_o (fall)
    );

    assign accept      = valid && !buf_full_q;
    // The frame starts on the fall event that wraps bit_idx back to 0.
    assign frame_start = fall && (bit_idx_q == IDX_LAST);

    always_comb begin
        // NOTE: every next-state value is given a default before any branch,
        // so no path leaves one unassigned and no latch is inferred.
        buf_full_d = buf_full_q;
        bit_idx_d  = bit_idx_q;
        shreg_d    = shreg_q;
        lrclk_d    = lrclk_q;
        underrun_d = 1'b0;

        if (accept) begin
            buf_full_d = 1'b1;
        end

        if (fall) begin
            bit_idx_d = frame_start ? '0 : bit_idx_q + 1'b1;

            if (frame_start) begin
                // A full buffer cannot also accept this cycle (ready is low),
                // so clearing it here never loses a pair. An empty buffer may
                // accept now; that pair is kept for the next frame.
                if (buf_full_q) begin
                    shreg_d    = {left_buf_q, right_buf_q};
                    buf_full_d = 1'b0;
                end else begin
                    shreg_d    = '0;
                    underrun_d = 1'b1;
                end
            end else begin
                shreg_d = {shreg_q[FRAME_BITS-2:0], 1'b0};
            end

            // Word select leads each channel's MSB by one bit period.
            if (bit_idx_d == IDX_LEFT_END) begin
                lrclk_d = 1'b1;
            end else if (bit_idx_d == IDX_LAST) begin
                lrclk_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so every flop
        // sees pre-edge values regardless of statement order.
        if (reset) begin
            buf_full_q <= 1'b0;
            bit_idx_q  <= IDX_LAST;
            shreg_q    <= '0;
            lrclk_q    <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            buf_full_q <= buf_full_d;
            bit_idx_q  <= bit_idx_d;
            shreg_q    <= shreg_d;
            lrclk_q    <= lrclk_d;
            underrun_q <= underrun_d;
        end
    end

    // NOTE: the sample buffer is only read while buf_full_q is set, so its
    // contents need no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            left_buf_q  <= left;
            right_buf_q <= right;
        end
    end

    assign ready    = !buf_full_q;
    assign lrclk    = lrclk_q;
    assign sdata    = shreg_q[FRAME_BITS-1];
    assign underrun = underrun_q;

endmodule
